bloque_cache: RTL and testbench



---
 rtl/bloque_cache.sv | 58 +++++
 tb/tb_bloque_cache.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bloque_cache.sv
// Single-port cache data array with synchronous clear, full-line refill and 32-bit lane stores.
// Define BLOQUE_CACHE_WRITE_FIRST_EN to return the merged post-write line on a same-address read.
module bloque_cache #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              gen_reset,
  input  logic              write_enable,
  input  logic [1:0]        write_enable_cpu,
  input  logic              write_enable_ram,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] adress,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned Lane  = DATA_W / 2;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [DATA_W-1:0] line_old, line_new;
  logic [1:0]        lane_we;
  logic              do_write;

  always_comb begin
    // A refill owns the whole line, so the CPU mask is irrelevant then.
    lane_we  = write_enable_ram ? 2'b11 : write_enable_cpu;
    do_write = write_enable & (|lane_we);
    line_old = mem_q[adress];
    line_new = line_old;
    if (lane_we[0]) line_new[Lane-1:0]      = data_in[Lane-1:0];
    if (lane_we[1]) line_new[DATA_W-1:Lane] = data_in[DATA_W-1:Lane];

    data_out_d = data_out_q;
    if (read_enable) begin
`ifdef BLOQUE_CACHE_WRITE_FIRST_EN
      data_out_d = do_write ? line_new : line_old;
`else
      data_out_d = line_old;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (gen_reset) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      data_out_q <= '0;
    end else begin
      if (do_write) mem_q[adress] <= line_new;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_bloque_cache.sv
// Bench for bloque_cache: array-level reference model checked every cycle, plus literal pins.
module tb_bloque_cache;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 64;

  logic          clk;
  logic          gen_reset;
  logic          write_enable;
  logic [1:0]    write_enable_cpu;
  logic          write_enable_ram;
  logic          read_enable;
  logic [AW-1:0] adress;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;

  int checks = 0;
  int errors = 0;

  bloque_cache #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk              (clk),
    .gen_reset        (gen_reset),
    .write_enable     (write_enable),
    .write_enable_cpu (write_enable_cpu),
    .write_enable_ram (write_enable_ram),
    .read_enable      (read_enable),
    .adress           (adress),
    .data_in          (data_in),
    .data_out         (data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a plain array of lines and the expected read register.
  logic [DW-1:0] model_mem [2**AW];
  logic [DW-1:0] model_out;
  bit            model_valid = 1'b0;

  always @(posedge clk) begin
    logic [DW-1:0] old_line, mask, new_line;
    bit            wr;
    if (gen_reset) begin
      foreach (model_mem[i]) model_mem[i] = '0;
      model_out   = '0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      old_line = model_mem[adress];
      mask = '0;
      if (write_enable_ram || write_enable_cpu[0]) mask = mask | {{(DW/2){1'b0}}, {(DW/2){1'b1}}};
      if (write_enable_ram || write_enable_cpu[1]) mask = mask | {{(DW/2){1'b1}}, {(DW/2){1'b0}}};
      wr = write_enable && (mask != '0);
      new_line = wr ? ((old_line & ~mask) | (data_in & mask)) : old_line;
      if (read_enable) begin
`ifdef BLOQUE_CACHE_WRITE_FIRST_EN
        model_out = new_line;
`else
        model_out = old_line;
`endif
      end
      model_mem[adress] = new_line;
    end
  end

  always @(negedge clk) begin
    if (model_valid) check("model", data_out, model_out);
  end

  task automatic cyc(input logic rst, input logic we, input logic [1:0] cpu, input logic ram,
                     input logic re, input logic [AW-1:0] a, input logic [DW-1:0] d);
    gen_reset        = rst;
    write_enable     = we;
    write_enable_cpu = cpu;
    write_enable_ram = ram;
    read_enable      = re;
    adress           = a;
    data_in          = d;
    @(negedge clk);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, a, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] rdw_exp, lane_rdw_exp;
`ifdef BLOQUE_CACHE_WRITE_FIRST_EN
    rdw_exp      = 64'd25;
    lane_rdw_exp = 64'hAAAA_BBBB_3333_4444;
`else
    rdw_exp      = 64'd0;
    lane_rdw_exp = 64'hAAAA_BBBB_CCCC_DDDD;
`endif
    @(negedge clk);
    cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, '0, '0);
    check("reset_out", data_out, 64'd0);
    rd(10'd1);
    check("reset_line1", data_out, 64'd0);
    rd(10'h3FF);
    check("reset_line3ff", data_out, 64'd0);

    cyc(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 10'd1, 64'd15);
    rd(10'd1);
    check("ram_write", data_out, 64'd15);

    cyc(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 10'd1, 64'hAAAA_BBBB_CCCC_DDDD);
    rd(10'd1);
    check("cpu_low", data_out, 64'h0000_0000_CCCC_DDDD);
    cyc(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 10'd1, 64'hAAAA_BBBB_CCCC_DDDD);
    rd(10'd1);
    check("cpu_high", data_out, 64'hAAAA_BBBB_CCCC_DDDD);
    cyc(1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 10'd1, 64'd0);
    rd(10'd1);
    check("we_off", data_out, 64'hAAAA_BBBB_CCCC_DDDD);
    cyc(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 10'd1, 64'd0);
    rd(10'd1);
    check("cpu_none", data_out, 64'hAAAA_BBBB_CCCC_DDDD);

    cyc(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 10'h02C, 64'd25);
    check("rdw_full", data_out, rdw_exp);
    rd(10'h02C);
    check("rdw_after", data_out, 64'd25);

    cyc(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 10'd1, 64'h1111_2222_3333_4444);
    check("rdw_lane", data_out, lane_rdw_exp);
    rd(10'd1);
    check("rdw_lane_after", data_out, 64'hAAAA_BBBB_3333_4444);

    cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 10'h000, '0);
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 10'h02C, '0);
    check("hold", data_out, 64'hAAAA_BBBB_3333_4444);

    cyc(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 10'h3FF, 64'd100);
    rd(10'h3FF);
    check("top_line", data_out, 64'd100);
    rd(10'h000);
    check("line0", data_out, 64'd0);

    cyc(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 10'd7, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(10'd7);
    check("ram_over_cpu", data_out, 64'hFFFF_FFFF_FFFF_FFFF);

    cyc(1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 10'd5, 64'd7);
    check("reset_mid_write", data_out, 64'd0);
    rd(10'd5);
    check("reset_line5", data_out, 64'd0);
    rd(10'd1);
    check("reset_line1b", data_out, 64'd0);
    rd(10'h3FF);
    check("reset_line3ffb", data_out, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
